// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and opcodes for the two-requester ALU arbiter.
// The opcode encodings are shared with the ALU users.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] OP_OR   = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_NOTA = 3'b100;
   localparam logic [2:0] OP_SHL1 = 3'b101;
   localparam logic [2:0] OP_SHR1 = 3'b110;
   localparam logic [2:0] OP_ZERO = 3'b111;

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational grant selection between two requesters.
// With ALU_ARB_RR_EN defined a conflict goes to the requester not served last;
// otherwise requester 0 always wins a conflict and no history is needed.
module alu_arb_pick (
   input  logic i_valid0,
   input  logic i_valid1,
`ifdef ALU_ARB_RR_EN
   input  logic i_last,
`endif
   output logic o_grant,
   output logic o_any
);

   // Grant index and any-valid from the current request valids
   always_comb begin
      o_any = i_valid0 | i_valid1;
`ifdef ALU_ARB_RR_EN
      if (i_valid0 && i_valid1) begin
         o_grant = ~i_last;
      end else begin
         o_grant = i_valid1;
      end
`else
      o_grant = ~i_valid0 & i_valid1;
`endif
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// One operation in flight: accept (IDLE) -> drive ALU (EXEC) -> hold result (RESP).
// Optional macro ALU_ARB_RR_EN selects round-robin conflict resolution;
// without it requester 0 has fixed priority.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_sel,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_sel,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_y,
   output logic             rsp0_zero,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_y,
   output logic             rsp1_zero,
   output logic [2:0]       alu_select,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_zero
);

   state_t           r_state;
   logic             r_owner;
   logic [2:0]       r_sel;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_y;
   logic             r_zero;
   logic             r_rsp0_valid;
   logic             r_rsp1_valid;

   logic             w_grant;
   logic             w_any;
   logic             w_accept;
   logic             w_rsp_ready;

`ifdef ALU_ARB_RR_EN
   logic             r_last;
`endif

   alu_arb_pick u_pick (
      .i_valid0 (req0_valid),
      .i_valid1 (req1_valid),
`ifdef ALU_ARB_RR_EN
      .i_last   (r_last),
`endif
      .o_grant  (w_grant),
      .o_any    (w_any)
   );

   // Any valid request in IDLE is accepted from the granted requester
   assign w_accept    = (r_state == IDLE) && w_any;
   assign req0_ready  = w_accept && !w_grant;
   assign req1_ready  = w_accept && w_grant;
   assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

   // Control FSM with operand latch, result capture and registered response valids
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_sel        <= OP_OR;
         r_a          <= '0;
         r_b          <= '0;
         r_y          <= '0;
         r_zero       <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_owner <= w_grant;
                  r_sel   <= w_grant ? req1_sel : req0_sel;
                  r_a     <= w_grant ? req1_a   : req0_a;
                  r_b     <= w_grant ? req1_b   : req0_b;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_y          <= alu_y;
               r_zero       <= alu_zero;
               r_rsp0_valid <= !r_owner;
               r_rsp1_valid <= r_owner;
               r_state      <= RESP;
            end
            RESP: begin
               if (w_rsp_ready) begin
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_rsp0_valid <= 1'b0;
               r_rsp1_valid <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

`ifdef ALU_ARB_RR_EN
   // Remember the last accepted requester; reset to 1 so requester 0 wins first
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (w_accept) begin
         r_last <= w_grant;
      end
   end
`endif

   // ALU is driven straight from the operand registers; both response ports share results
   assign alu_select = r_sel;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign rsp0_valid = r_rsp0_valid;
   assign rsp1_valid = r_rsp1_valid;
   assign rsp0_y     = r_y;
   assign rsp1_y     = r_y;
   assign rsp0_zero  = r_zero;
   assign rsp1_zero  = r_zero;

endmodule
